// File: rtl/tm1638_responder_if.sv
// rtl/tm1638_responder_if.sv - TM1638 STB/CLK/DIO bus bundle
// Purpose: groups the three-wire TM1638 link as seen at the device pins.
// Signals:
//   stb     strobe from master, low = frame active
//   sclk    bus clock from master, idle high
//   dio_in  DIO pin value driven by the master
//   dio_out key data bit driven by the responder
//   dio_oe  1 = responder drives DIO
interface tm1638_responder_if;
  logic stb;
  logic sclk;
  logic dio_in;
  logic dio_out;
  logic dio_oe;

  modport master (output stb, output sclk, output dio_in, input dio_out, input dio_oe);
  modport slave  (input stb, input sclk, input dio_in, output dio_out, output dio_oe);
endinterface

// File: rtl/tm1638_responder.sv
// rtl/tm1638_responder.sv - TM1638 device-side responder (display RAM + key scan readback)
// Purpose: oversamples the STB/SCLK/DIO link, decodes data/display/address commands,
//   holds the 16-byte display RAM and returns four key-scan bytes on DIO.
// Ports:
//   clk       system clock, all logic on rising edge
//   rst       synchronous reset, active high
//   bus       TM1638 pin bundle (slave side)
//   keys      key-scan bytes {b3,b2,b1,b0}, b0 sent first
//   disp_ram  display RAM, byte n at [8n+7:8n]
//   disp_on   display control bit3
//   bright    display control bits[2:0]
//   frame     1-cycle pulse at every STB rising edge
//   err       1-cycle pulse on protocol error
module tm1638_responder #(
  parameter int C_SYNC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  tm1638_responder_if.slave    bus,
  input  logic [31:0]          keys,
  output logic [127:0]         disp_ram,
  output logic                 disp_on,
  output logic [2:0]           bright,
  output logic                 frame,
  output logic                 err
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RD, S_IGNORE} state_t;

  state_t state, state_nxt;

  logic [C_SYNC-1:0] stb_sync, sclk_sync, dio_sync;
  logic stb_q, sclk_q, armed;
  logic stb_s, sclk_s, dio_s;
  logic stb_rise, stb_fall, sclk_rise, sclk_fall;

  logic [2:0]   bit_cnt;
  logic [7:0]   shreg;
  logic [7:0]   new_byte;
  logic [3:0]   ptr;
  logic         fixed;
  logic [31:0]  key_sr;
  logic [127:0] ram_q;

  logic collecting, bit_take, byte_done;
  logic do_data, do_disp, do_addr, do_write, err_set, rd_shift;

  // STB syncs to 0 so a low STB at reset release never looks like a fall;
  // SCLK syncs to its idle-high level.
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_sync  <= '0;
      sclk_sync <= '1;
      dio_sync  <= '0;
      stb_q     <= 1'b0;
      sclk_q    <= 1'b1;
      armed     <= 1'b0;
    end else begin
      stb_sync  <= {stb_sync[C_SYNC-2:0], bus.stb};
      sclk_sync <= {sclk_sync[C_SYNC-2:0], bus.sclk};
      dio_sync  <= {dio_sync[C_SYNC-2:0], bus.dio_in};
      stb_q     <= stb_s;
      sclk_q    <= sclk_s;
      if (stb_q) armed <= 1'b1;
    end
  end

  assign stb_s  = stb_sync[C_SYNC-1];
  assign sclk_s = sclk_sync[C_SYNC-1];
  assign dio_s  = dio_sync[C_SYNC-1];

  // A fall needs STB seen high since reset; the first rise after reset
  // (STB returning high) is not a frame end.
  assign stb_fall  = stb_q & ~stb_s;
  assign stb_rise  = armed & ~stb_q & stb_s;
  assign sclk_rise = ~sclk_q & sclk_s;
  assign sclk_fall = sclk_q & ~sclk_s;

  assign collecting = (state == S_CMD) || (state == S_WDATA) || (state == S_IGNORE);
  assign bit_take   = collecting & sclk_rise & ~stb_rise;
  assign byte_done  = bit_take & (bit_cnt == 3'd7);
  assign new_byte   = {dio_s, shreg[7:1]};   // LSB first: shift right, newest bit on top

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stb_rise) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (stb_fall) state_nxt = S_CMD;
        S_CMD: begin
          if (byte_done) begin
            case (new_byte[7:6])
              2'b01:   state_nxt = new_byte[1] ? S_RD : S_IGNORE;
              2'b11:   state_nxt = S_WDATA;
              default: state_nxt = S_IGNORE;
            endcase
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    do_data  = 1'b0;
    do_disp  = 1'b0;
    do_addr  = 1'b0;
    err_set  = 1'b0;
    if ((state == S_CMD) && byte_done) begin
      case (new_byte[7:6])
        2'b01:   do_data = 1'b1;
        2'b10:   do_disp = 1'b1;
        2'b11:   do_addr = 1'b1;
        default: err_set = 1'b1;
      endcase
    end
    if ((state == S_IGNORE) && byte_done) err_set = 1'b1;
    do_write = (state == S_WDATA) && byte_done;
    rd_shift = (state == S_RD) && sclk_fall && !stb_rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      ptr         <= '0;
      fixed       <= 1'b0;
      key_sr      <= '0;
      ram_q       <= '0;
      disp_on     <= 1'b0;
      bright      <= '0;
      frame       <= 1'b0;
      err         <= 1'b0;
      bus.dio_out <= 1'b0;
      bus.dio_oe  <= 1'b0;
    end else begin
      frame <= stb_rise;
      err   <= err_set;

      if (stb_rise || stb_fall) begin
        bit_cnt <= '0;
      end else if (bit_take) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= new_byte;
      end

      if (do_data) begin
        fixed <= new_byte[2];
        if (new_byte[1]) key_sr <= keys;
      end

      if (do_disp) begin
        disp_on <= new_byte[3];
        bright  <= new_byte[2:0];
      end

      if (do_addr) begin
        ptr <= new_byte[3:0];
      end else if (do_write) begin
        ram_q[{ptr, 3'b000} +: 8] <= new_byte;
        if (!fixed) ptr <= ptr + 4'd1;
      end

      // key_sr drains to zero, so bits past the 32nd read back as 0
      if (stb_rise) begin
        bus.dio_oe  <= 1'b0;
        bus.dio_out <= 1'b0;
      end else if (rd_shift) begin
        bus.dio_oe  <= 1'b1;
        bus.dio_out <= key_sr[0];
        key_sr      <= {1'b0, key_sr[31:1]};
      end
    end
  end

  assign disp_ram = ram_q;

endmodule
